// File: rtl/uc_stack.sv
// uc_stack: combinational instruction decode with an internal return-address
// stack for CALL/RET, a HALT state left by a resume pulse, and a sticky FAULT
// state on stack overflow/underflow.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RUN   | normal decode of the current instruction word
// ST_HALT  | PC frozen, no writes; a resume pulse steps past HALT and runs
// ST_FAULT | stack over/underflow seen; PC frozen until reset
module uc_stack #(
  parameter int PC_W  = 10,
  parameter int DEPTH = 4,
  localparam int SP_W = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [5:0]      opcode,
  input  logic            z,
  input  logic [PC_W-1:0] pc_plus1,
  input  logic            resume,
  output logic            s_inc,
  output logic            s_ret,
  output logic            s_inm,
  output logic            we3,
  output logic            wez,
  output logic [2:0]      op_alu,
  output logic            pc_en,
  output logic [PC_W-1:0] ret_addr,
  output logic [SP_W-1:0] sp,
  output logic            halted,
  output logic            fault
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [SP_W-1:0] DEPTH_SP = SP_W'(DEPTH);

  state_t          state, state_nx;
  logic            push, pop;
  logic [PC_W-1:0] stack_mem [DEPTH];

  // State, stack pointer and stack storage; reset wins over any push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
      sp    <= '0;
      for (int i = 0; i < DEPTH; i++) stack_mem[i] <= '0;
    end else begin
      state <= state_nx;
      if (push) begin
        sp <= sp + SP_W'(1);
        for (int i = 0; i < DEPTH; i++)
          if (sp == SP_W'(i)) stack_mem[i] <= pc_plus1;
      end else if (pop) begin
        sp <= sp - SP_W'(1);
      end
    end
  end

  // Decode and next-state; every output starts from the sequential-step baseline.
  always_comb begin
    s_inc    = 1'b1;
    s_ret    = 1'b0;
    s_inm    = 1'b0;
    we3      = 1'b0;
    wez      = 1'b0;
    op_alu   = 3'b000;
    pc_en    = 1'b1;
    push     = 1'b0;
    pop      = 1'b0;
    state_nx = state;
    if (reset) begin
      pc_en = 1'b0;
    end else begin
      unique case (state)
        ST_RUN: begin
          casez (opcode)
            6'b0000??: begin
              s_inm = 1'b1;
              we3   = 1'b1;
              wez   = 1'b1;
            end
            6'b1?????: begin
              we3    = 1'b1;
              wez    = 1'b1;
              op_alu = opcode[4:2];
            end
            6'b001000: s_inc = 1'b0;
            6'b001001: s_inc = ~z;
            6'b001010: s_inc = z;
            6'b001011: begin
              if (sp < DEPTH_SP) begin
                s_inc = 1'b0;
                push  = 1'b1;
              end else begin
                pc_en    = 1'b0;
                state_nx = ST_FAULT;
              end
            end
            6'b001100: begin
              if (sp != '0) begin
                s_ret = 1'b1;
                pop   = 1'b1;
              end else begin
                pc_en    = 1'b0;
                state_nx = ST_FAULT;
              end
            end
            6'b001101: begin
              pc_en    = 1'b0;
              state_nx = ST_HALT;
            end
            default: ;
          endcase
        end
        ST_HALT: begin
          if (resume) state_nx = ST_RUN;
          else        pc_en    = 1'b0;
        end
        ST_FAULT: pc_en = 1'b0;
        default: begin
          pc_en    = 1'b0;
          state_nx = ST_FAULT;
        end
      endcase
    end
  end

  // Top-of-stack view; empty stack reads as zero so stale entries never leak.
  always_comb begin
    ret_addr = '0;
    for (int i = 0; i < DEPTH; i++)
      if (sp == SP_W'(i + 1)) ret_addr = stack_mem[i];
  end

  assign halted = (state == ST_HALT);
  assign fault  = (state == ST_FAULT);

endmodule

// File: tb/tb_uc_stack.sv
// Self-checking bench for uc_stack: a queue-based reference model predicts
// every cycle's outputs, which go through a scoreboard queue and are compared
// once the combinational outputs have settled.
module tb_uc_stack;

  localparam int PC_W  = 10;
  localparam int DEPTH = 4;
  localparam int SP_W  = $clog2(DEPTH + 1);

  localparam logic [5:0] OP_J    = 6'b001000;
  localparam logic [5:0] OP_JZ   = 6'b001001;
  localparam logic [5:0] OP_JNZ  = 6'b001010;
  localparam logic [5:0] OP_CALL = 6'b001011;
  localparam logic [5:0] OP_RET  = 6'b001100;
  localparam logic [5:0] OP_HALT = 6'b001101;
  localparam logic [5:0] OP_NOP  = 6'b001110;
  localparam logic [5:0] OP_LI   = 6'b000011;

  logic            clk, reset, z, resume;
  logic [5:0]      opcode;
  logic [PC_W-1:0] pc_plus1;
  logic            s_inc, s_ret, s_inm, we3, wez, pc_en, halted, fault;
  logic [2:0]      op_alu;
  logic [PC_W-1:0] ret_addr;
  logic [SP_W-1:0] sp;

  uc_stack #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .z(z), .pc_plus1(pc_plus1),
    .resume(resume), .s_inc(s_inc), .s_ret(s_ret), .s_inm(s_inm), .we3(we3),
    .wez(wez), .op_alu(op_alu), .pc_en(pc_en), .ret_addr(ret_addr), .sp(sp),
    .halted(halted), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [8:0] ctl;   // {s_inc, s_ret, s_inm, we3, wez, op_alu, pc_en}
    logic [9:0] ret;
    logic [4:0] stat;  // {sp, halted, fault}
  } exp_t;

  exp_t             exp_q[$];
  logic [PC_W-1:0]  m_stk[$];
  int               m_st;  // 0 run, 1 halt, 2 fault
  int               n_chk, n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  task automatic step(input string tag, input logic rst, input logic [5:0] op,
                      input logic zz, input logic [PC_W-1:0] pcp, input logic res);
    exp_t e;
    logic si, sr, sm, w3, wz, pe;
    logic [2:0] oa;
    @(negedge clk);
    reset = rst; opcode = op; z = zz; pc_plus1 = pcp; resume = res;
    si = 1; sr = 0; sm = 0; w3 = 0; wz = 0; oa = 0; pe = 1;
    if (rst) pe = 0;
    else if (m_st == 0) begin
      if (op[5]) begin w3 = 1; wz = 1; oa = op[4:2]; end
      else if (op[5:2] == 4'b0000) begin sm = 1; w3 = 1; wz = 1; end
      else if (op == OP_J)    si = 0;
      else if (op == OP_JZ)   si = !zz;
      else if (op == OP_JNZ)  si = zz;
      else if (op == OP_CALL) begin if (m_stk.size() < DEPTH) si = 0; else pe = 0; end
      else if (op == OP_RET)  begin if (m_stk.size() > 0) sr = 1; else pe = 0; end
      else if (op == OP_HALT) pe = 0;
    end else if (m_st == 1) begin
      if (!res) pe = 0;
    end else pe = 0;
    e.tag  = tag;
    e.ctl  = {si, sr, sm, w3, wz, oa, pe};
    e.ret  = (m_stk.size() > 0) ? m_stk[$] : '0;
    e.stat = {3'(m_stk.size()), m_st == 1, m_st == 2};
    exp_q.push_back(e);
    #2;
    e = exp_q.pop_front();
    check({e.tag, ".ctl"},  32'({s_inc, s_ret, s_inm, we3, wez, op_alu, pc_en}), 32'(e.ctl));
    check({e.tag, ".ret"},  32'(ret_addr), 32'(e.ret));
    check({e.tag, ".stat"}, 32'({sp, halted, fault}), 32'(e.stat));
    @(posedge clk);
    if (rst) begin
      m_stk.delete();
      m_st = 0;
    end else if (m_st == 0) begin
      if (op == OP_CALL) begin
        if (m_stk.size() < DEPTH) m_stk.push_back(pcp); else m_st = 2;
      end else if (op == OP_RET) begin
        if (m_stk.size() > 0) void'(m_stk.pop_back()); else m_st = 2;
      end else if (op == OP_HALT) m_st = 1;
    end else if (m_st == 1) begin
      if (res) m_st = 0;
    end
  endtask

  initial begin
    logic [5:0] rop;
    n_chk = 0; n_pass = 0; m_st = 0;
    reset = 1; opcode = 0; z = 0; pc_plus1 = 0; resume = 0;
    @(posedge clk);
    step("rst_forced", 1, OP_CALL, 0, 10'h3ff, 0);
    step("rst_idle", 0, OP_NOP, 0, 10'h001, 0);

    for (int o = 0; o < 8; o++) step($sformatf("alu%0d", o), 0, {1'b1, 3'(o), 2'b00}, 0, 10'h002, 0);
    step("li", 0, OP_LI, 1, 10'h003, 0);
    step("nop_hi", 0, 6'b011111, 1, 10'h004, 0);
    step("j", 0, OP_J, 0, 10'h005, 0);
    step("jz_z1", 0, OP_JZ, 1, 10'h006, 0);
    step("jz_z0", 0, OP_JZ, 0, 10'h007, 0);
    step("jnz_z1", 0, OP_JNZ, 1, 10'h008, 0);
    step("jnz_z0", 0, OP_JNZ, 0, 10'h009, 0);
    step("resume_in_run", 0, OP_NOP, 0, 10'h00a, 1);

    step("call1", 0, OP_CALL, 0, 10'h011, 0);
    step("call2", 0, OP_CALL, 0, 10'h022, 0);
    step("call3", 0, OP_CALL, 0, 10'h033, 0);
    step("ret1", 0, OP_RET, 0, 10'h100, 0);
    step("ret2", 0, OP_RET, 0, 10'h101, 0);
    step("ret3", 0, OP_RET, 0, 10'h102, 0);
    step("after_rets", 0, OP_NOP, 0, 10'h103, 0);
    step("call_b2b", 0, OP_CALL, 0, 10'h155, 0);
    step("ret_b2b", 0, OP_RET, 0, 10'h156, 0);

    for (int i = 0; i < 4; i++) step($sformatf("fill%0d", i), 0, OP_CALL, 0, 10'(10'h040 + i), 0);
    step("overflow", 0, OP_CALL, 0, 10'h0aa, 0);
    step("fault_resume", 0, OP_ALU_ADD(), 0, 10'h0ab, 1);
    step("fault_hold", 0, OP_RET, 0, 10'h0ac, 1);
    step("fault_rst", 1, OP_NOP, 0, 10'h0ad, 1);
    step("fault_clr", 0, OP_NOP, 0, 10'h0ae, 0);
    step("underflow", 0, OP_RET, 0, 10'h0af, 0);
    step("uflt_resume", 0, OP_CALL, 0, 10'h0b0, 1);
    step("uflt_rst", 1, OP_NOP, 0, 10'h0b1, 0);

    step("halt", 0, OP_HALT, 0, 10'h0c0, 0);
    for (int i = 0; i < 5; i++) step($sformatf("halt_wait%0d", i), 0, (i[0] ? OP_CALL : 6'b110000), 1, 10'h0c1, 0);
    step("resume", 0, OP_HALT, 0, 10'h0c2, 1);
    step("post_resume", 0, OP_LI, 0, 10'h0c3, 0);

    step("pre_call_a", 0, OP_CALL, 0, 10'h201, 0);
    step("pre_call_b", 0, OP_CALL, 0, 10'h202, 0);
    step("rst_with_call", 1, OP_CALL, 0, 10'h203, 0);
    step("after_rst", 0, OP_NOP, 0, 10'h204, 0);
    step("after_rst_call", 0, OP_CALL, 0, 10'h205, 0);
    step("after_rst_ret", 0, OP_RET, 0, 10'h206, 0);

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 6))
        0: rop = OP_CALL;
        1: rop = OP_CALL;
        2: rop = OP_RET;
        3: rop = OP_HALT;
        4: rop = 6'($urandom_range(0, 63));
        5: rop = OP_JZ;
        default: rop = OP_RET;
      endcase
      step($sformatf("rnd%0d", i), ($urandom_range(0, 19) == 0), rop,
           1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  function automatic logic [5:0] OP_ALU_ADD();
    return 6'b100100;
  endfunction

endmodule
